// File: rtl/sr_master_slave.sv
// Master-slave SR flip-flop: master SR latch open while clk=1, slave open while clk=0.
// Optional build macro SR_MS_SET_DOMINANT_EN makes s=r=1 set the master instead of holding.
module sr_master_slave #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] qm,
    output logic [WIDTH-1:0] qs
);

    logic [WIDTH-1:0] set_cmd;
    logic [WIDTH-1:0] clr_cmd;
    logic [WIDTH-1:0] qm_q;
    logic [WIDTH-1:0] qs_q;

    // Decode each slice's request into an explicit set or clear; s=r=1 never yields both.
    always_comb begin
        set_cmd = '0;
        clr_cmd = '0;
`ifdef SR_MS_SET_DOMINANT_EN
        set_cmd = s;
        clr_cmd = r & ~s;
`else
        set_cmd = s & ~r;
        clr_cmd = r & ~s;
`endif
    end

    // NOTE: these are real level-sensitive latches; always_latch with non-blocking
    // updates keeps the master/slave hand-off race-free at both clock edges.
    always_latch begin
        if (rst) begin
            qm_q <= '0;
        end else if (clk) begin
            qm_q <= (qm_q & ~clr_cmd) | set_cmd;
        end
    end

    always_latch begin
        if (rst) begin
            qs_q <= '0;
        end else if (!clk) begin
            qs_q <= qm_q;
        end
    end

    assign qm = qm_q;
    assign qs = qs_q;

endmodule

// File: tb/tb_sr_master_slave.sv
// Self-checking bench for sr_master_slave: behavioural model checked every half cycle,
// plus hand-computed literal expectations for reset, hold, set-dominance and ones-catching.
module tb_sr_master_slave;

    localparam int W = 4;
`ifdef SR_MS_SET_DOMINANT_EN
    localparam bit DOM = 1'b1;
`else
    localparam bit DOM = 1'b0;
`endif
    localparam logic [W-1:0] ALL  = 4'hF;
    localparam logic [W-1:0] NONE = 4'h0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s   = '0;
    logic [W-1:0] r   = '0;
    logic [W-1:0] qm;
    logic [W-1:0] qs;

    logic [W-1:0] m_qm = '0;
    logic [W-1:0] m_qs = '0;
    int checks = 0;
    int errors = 0;

    sr_master_slave #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .s  (s),
        .r  (r),
        .qm (qm),
        .qs (qs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a command acts on the stored master bit per the SR truth table.
    task automatic m_apply();
        for (int i = 0; i < W; i++) begin
            if (s[i] && !r[i])      m_qm[i] = 1'b1;
            else if (r[i] && !s[i]) m_qm[i] = 1'b0;
            else if (s[i] && r[i] && DOM) m_qm[i] = 1'b1;
        end
    endtask

    task automatic drive(input logic [W-1:0] sv, input logic [W-1:0] rv);
        s = sv;
        r = rv;
        if (!rst && clk) m_apply();
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            m_qm = '0;
            m_qs = '0;
        end else if (clk) begin
            m_apply();
        end
    endtask

    // Model clock behaviour: rising edge lets held requests act, falling edge copies master to slave.
    always @(clk) begin
        #1;
        if (!rst) begin
            if (clk) m_apply();
            else     m_qs = m_qm;
        end
    end

    always @(clk) begin
        #3;
        check("model_qm", qm, m_qm);
        check("model_qs", qs, m_qs);
    end

    task automatic hi();
        @(posedge clk);
        #2;
    endtask

    task automatic lo();
        @(negedge clk);
        #2;
    endtask

    typedef struct packed {
        logic [W-1:0] sv;
        logic [W-1:0] rv;
    } vec_t;

    vec_t vecs [6] = '{
        '{4'b1010, 4'b0000}, '{4'b0110, 4'b1001}, '{4'b1111, 4'b0101},
        '{4'b0000, 4'b1100}, '{4'b0011, 4'b0011}, '{4'b1001, 4'b0110}
    };

    initial begin
        // Reset held with clock running and s set: outputs pinned low.
        drive(ALL, NONE);
        repeat (3) hi();
        #1 check("rst_qm", qm, NONE);
        lo();
        #1 check("rst_qs", qs, NONE);

        // Release during low phase: first high phase sets qm, next fall sets qs.
        lo();
        set_rst(1'b0);
        hi();
        #1 check("rel_qm", qm, ALL);
        lo();
        #1 check("rel_qs", qs, ALL);

        // Directed sequence: clear, set, hold, s=r=1.
        drive(NONE, ALL);
        hi();
        #1 check("seq_clr_qm", qm, NONE);
        lo();
        #1 check("seq_clr_qs", qs, NONE);
        drive(ALL, NONE);
        hi();
        #1 check("seq_set_qm", qm, ALL);
        lo();
        #1 check("seq_set_qs", qs, ALL);
        drive(NONE, NONE);
        hi();
        hi();
        #1 check("seq_hold_qm", qm, ALL);
        lo();
        #1 check("seq_hold_qs", qs, ALL);
        drive(ALL, ALL);
        hi();
        #1 check("seq_ss_qm", qm, ALL);
        lo();
        #1 check("seq_ss_qs", qs, ALL);

        // s=r=1 from a cleared state: holds 0 by default, sets under set-dominance.
        drive(NONE, ALL);
        hi();
        lo();
        #1 check("dom_pre_qs", qs, NONE);
        drive(ALL, ALL);
        hi();
        #1 check("dom_qm", qm, DOM ? ALL : NONE);
        lo();
        #1 check("dom_qs", qs, DOM ? ALL : NONE);

        // Ones-catching: a short s pulse in the high phase still sets the flop.
        drive(NONE, ALL);
        hi();
        drive(NONE, NONE);
        lo();
        #1 check("oc_pre_qs", qs, NONE);
        hi();
        drive(ALL, NONE);
        #1 check("oc_qm", qm, ALL);
        #1 drive(NONE, NONE);
        lo();
        #1 check("oc_qs", qs, ALL);

        // Low-phase isolation: requests toggled while clk=0 are ignored until the rise.
        drive(ALL, NONE);
        #1 drive(NONE, ALL);
        check("iso_qm", qm, ALL);
        check("iso_qs", qs, ALL);
        hi();
        #1 check("iso_rise_qm", qm, NONE);
        check("iso_rise_qs", qs, ALL);

        // Async reset mid high phase, then mixed per-slice requests.
        drive(ALL, NONE);
        lo();
        hi();
        check("ar_pre_qs", qs, ALL);
        set_rst(1'b1);
        #1 check("ar_qm", qm, NONE);
        check("ar_qs", qs, NONE);
        drive(4'b0101, 4'b0011);
        #1 check("ar_ignore_qm", qm, NONE);
        hi();
        set_rst(1'b0);
        #1 check("mix_qm", qm, DOM ? 4'b0101 : 4'b0100);
        lo();
        #1 check("mix_qs", qs, DOM ? 4'b0101 : 4'b0100);

        // Compact table of mixed vectors, checked against the model each half cycle.
        foreach (vecs[i]) begin
            lo();
            drive(vecs[i].sv, vecs[i].rv);
            hi();
        end
        drive(NONE, NONE);
        repeat (2) lo();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
